// File: rtl/fill_rect.sv
// Rectangle fill engine: paints a clipped rectangle (solid, checkerboard or
// border-only) onto the VGA plot/ready interface, one pixel per accepted cycle.
module fill_rect #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COLOUR_W  = 3,
    parameter int unsigned CELL_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [COLOUR_W-1:0] alt_colour,
    input  logic                vga_ready,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned XE_W = X_W + 1;
    localparam int unsigned YE_W = Y_W + 1;
    localparam logic [1:0]  MODE_CHECKER = 2'd1;
    localparam logic [1:0]  MODE_BORDER  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [X_W-1:0]      x0_q, w_q;
    logic [Y_W-1:0]      y0_q, h_q;
    logic [1:0]          mode_q;
    logic [COLOUR_W-1:0] colour_q, alt_q;

    logic [XE_W-1:0]     x_sum_c, x_end_c, x_last_c;
    logic [YE_W-1:0]     y_sum_c, y_end_c, y_last_c;
    logic                empty_c;

    logic [X_W-1:0]      x_d;
    logic [Y_W-1:0]      y_d;
    logic [COLOUR_W-1:0] colour_d;
    logic                plot_d, busy_d, done_d, latch_c, on_edge_c;

    // Clipped bounds; the extra bit keeps x0+w / y0+h from wrapping
    always_comb begin : clip
        x_sum_c  = XE_W'(x0_q) + XE_W'(w_q);
        y_sum_c  = YE_W'(y0_q) + YE_W'(h_q);
        x_end_c  = (x_sum_c > XE_W'(SCREEN_W)) ? XE_W'(SCREEN_W) : x_sum_c;
        y_end_c  = (y_sum_c > YE_W'(SCREEN_H)) ? YE_W'(SCREEN_H) : y_sum_c;
        x_last_c = x_end_c - XE_W'(1);
        y_last_c = y_end_c - YE_W'(1);
        empty_c  = (w_q == '0) || (h_q == '0)
                || (XE_W'(x0_q) >= XE_W'(SCREEN_W))
                || (YE_W'(y0_q) >= YE_W'(SCREEN_H));
    end

    // Next state plus the registered pixel for the next cursor position
    always_comb begin : fsm_next
        state_d   = state;
        x_d       = vga_x;
        y_d       = vga_y;
        plot_d    = 1'b0;
        latch_c   = 1'b0;
        on_edge_c = 1'b0;
        colour_d  = colour_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_c = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (empty_c) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAW;
                    x_d     = x0_q;
                    y_d     = y0_q;
                    plot_d  = 1'b1;
                end
            end
            S_DRAW: begin
                plot_d = 1'b1;
                // skipped border-interior positions advance regardless of ready
                if (!vga_plot || vga_ready) begin
                    if (YE_W'(vga_y) == y_last_c) begin
                        if (XE_W'(vga_x) == x_last_c) begin
                            state_d = S_DONE;
                            plot_d  = 1'b0;
                        end else begin
                            x_d = vga_x + X_W'(1);
                            y_d = y0_q;
                        end
                    end else begin
                        y_d = vga_y + Y_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        on_edge_c = (x_d == x0_q) || (XE_W'(x_d) == x_last_c)
                 || (y_d == y0_q) || (YE_W'(y_d) == y_last_c);
        if (mode_q == MODE_BORDER && !on_edge_c) begin
            plot_d = 1'b0;
        end
        if (mode_q == MODE_CHECKER && (x_d[CELL_LOG2] ^ y_d[CELL_LOG2])) begin
            colour_d = alt_q;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_DRAW);
        done_d = (state_d == S_DONE);
    end

    // State, request latch and output registers
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            mode_q     <= '0;
            colour_q   <= '0;
            alt_q      <= '0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            done       <= done_d;
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
            if (latch_c) begin
                x0_q     <= x0;
                y0_q     <= y0;
                w_q      <= w;
                h_q      <= h;
                mode_q   <= mode;
                colour_q <= colour;
                alt_q    <= alt_colour;
            end
        end
    end

endmodule

// File: doc/fill_rect.md
Name: fill_rect

Overview:
- Parametrised rectangle fill engine: the successor to the full-screen fill used by the snake game renderer.
- Paints an arbitrary clipped rectangle onto the VGA pixel interface, one pixel per accepted cycle.
- Supports three fill modes: solid, checkerboard and border-only.
- Sits between the game/render controller (start/done handshake) and the VGA adapter (plot/ready handshake). Used for background, board tiles, snake segments and the food marker.

Parameters:
- SCREEN_W, 160, visible columns; x coordinates valid 0..SCREEN_W-1
- SCREEN_H, 120, visible rows; y coordinates valid 0..SCREEN_H-1
- X_W, 8, width of x coordinate and rect width fields
- Y_W, 7, width of y coordinate and rect height fields
- COLOUR_W, 3, pixel colour width
- CELL_LOG2, 2, checkerboard cell edge = 2^CELL_LOG2 pixels

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; level-held by controller until done seen
- x0  in  X_W  rectangle left column
- y0  in  Y_W  rectangle top row
- w  in  X_W  rectangle width in pixels
- h  in  Y_W  rectangle height in pixels
- mode  in  2  0=SOLID, 1=CHECKER, 2=BORDER, 3=reserved (treated as SOLID)
- colour  in  COLOUR_W  primary colour
- alt_colour  in  COLOUR_W  secondary colour (checker odd cells)
- vga_ready  in  1  adapter accepts pixel this cycle
- busy  out  1  high in LOAD and DRAW
- done  out  1  high in DONE
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  pixel valid

Behaviour:
- Reset: state=IDLE; busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0. Reset mid-draw aborts immediately; no further plots.
- All outputs are registered.
- IDLE: when start=1, latch x0, y0, w, h, mode, colour and alt_colour, then go to LOAD. Inputs are ignored after latching.
- LOAD (1 cycle): compute clipped bounds in X_W+1 / Y_W+1 bits:
  - x_end = min(x0+w, SCREEN_W); y_end = min(y0+h, SCREEN_H).
  - If w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H: go to DONE with no plot.
  - Otherwise set cursor to (x0, y0) and go to DRAW.
- Latency: start sampled at cycle N gives first vga_plot at N+2.
- DRAW scan order: column-major; y inner loop (y0..y_end-1), x outer loop (x0..x_end-1). Last pixel is (x_end-1, y_end-1).
- Transfer rule:
  - A pixel is transferred on any cycle with vga_plot=1 and vga_ready=1; the cursor advances the next cycle.
  - While vga_ready=0, vga_x, vga_y, vga_colour and vga_plot hold stable.
  - With vga_ready held high, one pixel per cycle (no bubbles).
- Mode colour and plot rules:
  - SOLID: every pixel gets colour.
  - CHECKER: colour if ((x>>CELL_LOG2) xor (y>>CELL_LOG2)) bit0 == 0, else alt_colour. Uses absolute screen coordinates, so the pattern is independent of x0/y0.
  - BORDER: plot only pixels with x==x0, x==x_end-1, y==y0 or y==y_end-1, in colour. Interior positions are visited with vga_plot=0, one cycle each, independent of vga_ready.
- After the last position transfers (or is skipped): vga_plot=0 the next cycle; go to DONE.
- DONE: done=1 and stays high while start=1. When start=0: done=0 next cycle, return to IDLE.
- start held high across DONE does not retrigger; start must drop for at least 1 cycle.
- Degenerate shapes: 1-pixel-wide or 1-pixel-tall rectangles in BORDER mode plot every pixel.
- Clipping never wraps: x0+w overflow beyond X_W bits is handled by the extra bit.

Test Plan:
- Full screen SOLID: x0=0, y0=0, w=160, h=120, colour=3'b010, ready=1 → exactly 19200 plots. First (0,0) at N+2, last (159,119). done rises at N+2+19200.
- Backpressure: 2x2 SOLID at (10,20), ready toggling 1,0,0,1,... → outputs held stable while ready=0. Transfer order (10,20),(10,21),(11,20),(11,21), each transferred exactly once.
- Clipping: x0=150, y0=115, w=20, h=20 → plots x 150..159, y 115..119 (50 pixels). No coordinate ≥ screen size.
- CHECKER: x0=0, y0=0, w=8, h=8, colour=1, alt=6 → (0,0)=1, (4,0)=6, (4,4)=1, (3,7)=6.
- BORDER: 4x3 at (0,0) → 10 plots; (1,1) and (2,1) not plotted. Total cycles in DRAW = 12.
- Zero size and reset: w=0 → done at N+2 with no plot. Separately, rst asserted mid-DRAW → next cycle vga_plot=0, done=0, busy=0; a new start works normally afterwards.
